// File: rtl/csc_pkg.sv
// Shared definitions for the csc_pipe colour-space converter.
//   - csc_mode_e : conversion direction / standard selected by mode_i
//   - csc_ctrl_t : {bypass, mode}, the control word latched at each vs rise
//   - CSC_COEF   : 4 x 3 x 3 coefficient table, Q3.10 (x1024), indexed
//                  [mode][output row][input column]
//   - CSC_LAT    : fixed pipeline latency in clock cycles
package csc_pkg;

  localparam int CSC_LAT   = 4;
  localparam int CSC_FRAC  = 10;   // fractional bits of the coefficients
  localparam int CSC_Y_OFS = 16;   // studio-range luma offset at 8 bits
  localparam int CSC_C_OFS = 128;  // chroma mid-point at 8 bits

  typedef enum logic [1:0] {
    CSC_601_FWD = 2'd0,
    CSC_709_FWD = 2'd1,
    CSC_601_INV = 2'd2,
    CSC_709_INV = 2'd3
  } csc_mode_e;

  typedef struct packed {
    logic      bypass;
    csc_mode_e mode;
  } csc_ctrl_t;

  localparam int CSC_COEF [4][3][3] = '{
    '{'{ 263,  516,  100}, '{-152, -298,  450}, '{ 450, -377,  -73}},  // 601 fwd
    '{'{ 187,  629,   63}, '{-103, -347,  450}, '{ 450, -409,  -41}},  // 709 fwd
    '{'{1192,    0, 1634}, '{1192, -401, -832}, '{1192, 2066,    0}},  // 601 inv
    '{'{1192,    0, 1836}, '{1192, -218, -546}, '{1192, 2163,    0}}   // 709 inv
  };

  // Inverse modes have bit 1 set.
  function automatic logic csc_is_inv(csc_mode_e m);
    return m[1];
  endfunction

  // Offset of channel/row 'row' (0 = Y, 1/2 = chroma) scaled to dw bits.
  function automatic int csc_ofs(int row, int dw);
    return ((row == 0) ? CSC_Y_OFS : CSC_C_OFS) << (dw - 8);
  endfunction

endpackage

// File: rtl/csc_mac3.sv
// One output channel of the converter: stages S2..S4.
//   clk, rst          : pixel clock, synchronous active-high reset
//   valid             : pixel present in S1 (de)
//   bypass, inv       : control of that pixel (pass-through / YUV->RGB)
//   x0..x2            : S1 channel values, signed DW+1 bits
//   k0..k2            : coefficients for this row, signed Q3.10
//   raw               : untouched input channel, used in bypass
//   y                 : registered result; 0 when the pixel is not valid
// S2 multiplies, S3 sums/rounds/shifts and adds the forward offset OFS,
// S4 clamps to [0, 2^DW-1].
module csc_mac3 import csc_pkg::*; #(
  parameter int DW     = 8,
  parameter int COEF_W = 14,
  parameter int OFS    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic                     bypass,
  input  logic                     inv,
  input  logic signed [DW:0]       x0,
  input  logic signed [DW:0]       x1,
  input  logic signed [DW:0]       x2,
  input  logic signed [COEF_W-1:0] k0,
  input  logic signed [COEF_W-1:0] k1,
  input  logic signed [COEF_W-1:0] k2,
  input  logic [DW-1:0]            raw,
  output logic [DW-1:0]            y
);

  localparam int PW    = DW + 1 + COEF_W;  // exact product width
  localparam int ACC_W = DW + COEF_W + 3;  // room for three products plus rounding
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1 << (CSC_FRAC - 1));
  localparam logic signed [ACC_W-1:0] OFS_S = ACC_W'(OFS);
  localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'((1 << DW) - 1);

  // S2
  logic signed [PW-1:0] p0, p1, p2;
  logic                 valid2, bypass2, inv2;
  logic [DW-1:0]        raw2;
  // S3
  logic signed [ACC_W-1:0] sum, scaled, acc3;
  logic                    valid3, bypass3;
  logic [DW-1:0]           raw3;
  // S4 input
  logic [DW-1:0]           sat;

  // NOTE: every always_comb target is assigned unconditionally first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum    = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) + RND;
    scaled = sum >>> CSC_FRAC;
    if (!inv2) scaled = scaled + OFS_S;

    if (acc3[ACC_W-1])    sat = '0;
    else if (acc3 > MAXV) sat = '1;
    else                  sat = acc3[DW-1:0];
  end

  // NOTE: reset is sampled on the clock edge and clears every stage, which
  // flushes a partly filled pipeline; state uses <= so each stage takes the
  // previous stage's value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0      <= '0;
      p1      <= '0;
      p2      <= '0;
      valid2  <= 1'b0;
      bypass2 <= 1'b0;
      inv2    <= 1'b0;
      raw2    <= '0;
      acc3    <= '0;
      valid3  <= 1'b0;
      bypass3 <= 1'b0;
      raw3    <= '0;
      y       <= '0;
    end else begin
      p0      <= PW'(x0) * PW'(k0);
      p1      <= PW'(x1) * PW'(k1);
      p2      <= PW'(x2) * PW'(k2);
      valid2  <= valid;
      bypass2 <= bypass;
      inv2    <= inv;
      raw2    <= raw;

      acc3    <= scaled;
      valid3  <= valid2;
      bypass3 <= bypass2;
      raw3    <= raw2;

      if (!valid3)      y <= '0;
      else if (bypass3) y <= raw3;
      else              y <= sat;
    end
  end

endmodule

// File: rtl/csc_pipe.sv
// RGB <-> YCbCr (studio range) converter, BT.601 / BT.709, with bypass.
// Fixed LAT-cycle pipeline between the timing generator and frame memory.
//   clk_i, rst_i        : pixel clock, synchronous active-high reset
//   vs_i, hs_i, de_i    : video timing in
//   pix_i               : {c0,c1,c2}, each DW bits ({R,G,B} or {Y,Cb,Cr})
//   mode_i, bypass_i    : requested conversion, taken only at a vs rise
//   vs_o, hs_o, de_o    : timing delayed by LAT
//   pix_o               : converted pixel, 0 while de_o is low
//   mode_act_o          : {bypass,mode} currently in effect
// S1 (here) registers the input and removes YUV offsets for inverse modes;
// three csc_mac3 instances provide S2..S4, one per output channel.
module csc_pipe import csc_pkg::*; #(
  parameter int DW     = 8,
  parameter int COEF_W = 14,
  parameter int LAT    = CSC_LAT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            vs_i,
  input  logic            hs_i,
  input  logic            de_i,
  input  logic [3*DW-1:0] pix_i,
  input  logic [1:0]      mode_i,
  input  logic            bypass_i,
  output logic            vs_o,
  output logic            hs_o,
  output logic            de_o,
  output logic [3*DW-1:0] pix_o,
  output logic [2:0]      mode_act_o
);

  logic      vs_prev;
  csc_ctrl_t mode_act, ctrl_now;

  logic signed [DW:0] x_in [3];
  logic signed [DW:0] s1_x [3];
  logic               s1_de;
  csc_ctrl_t          s1_ctrl;
  logic [3*DW-1:0]    s1_raw;

  logic signed [COEF_W-1:0] coef [3][3];

  logic [LAT-1:0] vs_sr, hs_sr, de_sr;

  always_comb begin
    // A vs rise takes effect on its own edge, so a pixel arriving together
    // with the rise already uses the new control word.
    ctrl_now = mode_act;
    if (vs_i && !vs_prev) ctrl_now = csc_ctrl_t'({bypass_i, mode_i});

    for (int r = 0; r < 3; r++) begin
      x_in[r] = $signed({1'b0, pix_i[(2-r)*DW +: DW]});
      if (csc_is_inv(ctrl_now.mode)) x_in[r] = x_in[r] - (DW+1)'(csc_ofs(r, DW));
    end
  end

  // Coefficients follow the mode travelling with the pixel in S1.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        coef[r][c] = COEF_W'(CSC_COEF[s1_ctrl.mode][r][c]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_prev  <= 1'b0;
      mode_act <= '0;
      s1_de    <= 1'b0;
      s1_ctrl  <= '0;
      s1_raw   <= '0;
      for (int r = 0; r < 3; r++) s1_x[r] <= '0;
      vs_sr    <= '0;
      hs_sr    <= '0;
      de_sr    <= '0;
    end else begin
      vs_prev  <= vs_i;
      mode_act <= ctrl_now;
      s1_de    <= de_i;
      s1_ctrl  <= ctrl_now;
      s1_raw   <= pix_i;
      for (int r = 0; r < 3; r++) s1_x[r] <= x_in[r];
      vs_sr    <= {vs_sr[LAT-2:0], vs_i};
      hs_sr    <= {hs_sr[LAT-2:0], hs_i};
      de_sr    <= {de_sr[LAT-2:0], de_i};
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_ch
    csc_mac3 #(
      .DW     (DW),
      .COEF_W (COEF_W),
      .OFS    (csc_ofs(r, DW))
    ) u_mac (
      .clk    (clk_i),
      .rst    (rst_i),
      .valid  (s1_de),
      .bypass (s1_ctrl.bypass),
      .inv    (csc_is_inv(s1_ctrl.mode)),
      .x0     (s1_x[0]),
      .x1     (s1_x[1]),
      .x2     (s1_x[2]),
      .k0     (coef[r][0]),
      .k1     (coef[r][1]),
      .k2     (coef[r][2]),
      .raw    (s1_raw[(2-r)*DW +: DW]),
      .y      (pix_o[(2-r)*DW +: DW])
    );
  end

  assign vs_o       = vs_sr[LAT-1];
  assign hs_o       = hs_sr[LAT-1];
  assign de_o       = de_sr[LAT-1];
  assign mode_act_o = mode_act;

endmodule

// File: tb/tb_csc_pipe.sv
// Bench for csc_pipe: a DW=8 and a DW=10 instance share timing/control.
// A reference model converts each pixel with integer arithmetic and keeps
// the expected output stream in a queue; every cycle is compared, plus
// directed checks of hand-computed values.
module tb_csc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vs, hs, de, bp;
  logic [1:0]  md;
  logic [23:0] p8;
  logic [29:0] p10;

  logic        vs8, hs8, de8;
  logic [23:0] q8;
  logic [2:0]  ma8;
  logic        vs10, hs10, de10;
  logic [29:0] q10;
  logic [2:0]  ma10;

  csc_pipe #(.DW(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .pix_i(p8),
    .mode_i(md), .bypass_i(bp), .vs_o(vs8), .hs_o(hs8), .de_o(de8),
    .pix_o(q8), .mode_act_o(ma8)
  );

  csc_pipe #(.DW(10)) dut10 (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de), .pix_i(p10),
    .mode_i(md), .bypass_i(bp), .vs_o(vs10), .hs_o(hs10), .de_o(de10),
    .pix_o(q10), .mode_act_o(ma10)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rows of 3 coefficients (x1024): Y/Cb/Cr or R/G/B; index = mode.
  int kt [4][9] = '{
    '{ 263,  516,  100, -152, -298,  450,  450, -377,  -73},
    '{ 187,  629,   63, -103, -347,  450,  450, -409,  -41},
    '{1192,    0, 1634, 1192, -401, -832, 1192, 2066,    0},
    '{1192,    0, 1836, 1192, -218, -546, 1192, 2163,    0}
  };

  // Reference conversion of one pixel at width dw under control m={bypass,mode}.
  function automatic logic [35:0] conv(int dw, logic [2:0] m, logic [35:0] pix);
    int c [3];
    int acc, r, sh, mx;
    logic [35:0] res;
    sh  = dw - 8;
    mx  = (1 << dw) - 1;
    res = '0;
    if (m[2]) return pix;
    for (int i = 0; i < 3; i++) c[i] = int'((pix >> (dw * (2 - i))) & 36'(mx));
    if (m[1]) begin
      c[0] -= 16 << sh;
      c[1] -= 128 << sh;
      c[2] -= 128 << sh;
    end
    for (int row = 0; row < 3; row++) begin
      acc = 0;
      for (int j = 0; j < 3; j++) acc += kt[m[1:0]][row * 3 + j] * c[j];
      r = (acc + 512) >>> 10;
      if (!m[1]) r += ((row == 0) ? 16 : 128) << sh;
      if (r < 0) r = 0;
      else if (r > mx) r = mx;
      res = res | (36'(r) << (dw * (2 - row)));
    end
    return res;
  endfunction

  typedef struct packed {
    logic        vs, hs, de;
    logic [23:0] q8;
    logic [29:0] q10;
  } exp_t;

  exp_t       q [$];
  exp_t       cur;
  logic [2:0] m_mode    = 3'b000;
  logic       m_vs_prev = 1'b0;

  logic       d_hs = 1'b0;
  logic [1:0] d_md = 2'd0;
  logic       d_bp = 1'b0;

  // One clock: drive, let the model follow the edge, compare on the falling edge.
  task automatic step(input logic r, input logic v, input logic d,
                      input logic [23:0] a, input logic [29:0] b);
    exp_t        item;
    logic [35:0] t;
    rst = r; vs = v; hs = d_hs; de = d; md = d_md; bp = d_bp; p8 = a; p10 = b;
    @(posedge clk);
    if (r) begin
      m_mode    = 3'b000;
      m_vs_prev = 1'b0;
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back('0);
      cur = '0;
    end else begin
      if (v && !m_vs_prev) m_mode = {d_bp, d_md};
      m_vs_prev = v;
      item.vs  = v;
      item.hs  = d_hs;
      item.de  = d;
      t        = conv(8, m_mode, {12'd0, a});
      item.q8  = d ? t[23:0] : 24'd0;
      t        = conv(10, m_mode, {6'd0, b});
      item.q10 = d ? t[29:0] : 30'd0;
      q.push_back(item);
      cur = q.pop_front();
    end
    @(negedge clk);
    check("ctl8",  {vs8, hs8, de8, ma8},    {cur.vs, cur.hs, cur.de, m_mode});
    check("pix8",  q8,                      cur.q8);
    check("ctl10", {vs10, hs10, de10, ma10}, {cur.vs, cur.hs, cur.de, m_mode});
    check("pix10", q10,                     cur.q10);
  endtask

  logic [7:0] v8;
  logic [9:0] v10;

  initial begin
    for (int i = 0; i < 3; i++) q.push_back('0);

    // Reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_pix", q8, 24'd0);
    check("rst_mode", ma8, 3'd0);

    // Mode 0 (601 fwd): white then black, 4 cycles after de_i
    d_md = 2'd0;
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 24'hFFFFFF, 30'h3FFFFFFF);
    step(0, 1, 1, 24'h000000, 30'h0);
    step(0, 1, 0, 0, 0);
    check("lat_early_de", de8, 1'b0);
    step(0, 1, 0, 0, 0);
    check("white_de", de8, 1'b1);
    check("white601", q8, 24'hEB8080);
    // 879*1023 rounds to 878, +64 -> 942 under the +512/>>10 rule.
    check("white601_10", q10, {10'd942, 10'd512, 10'd512});
    step(0, 0, 0, 0, 0);
    check("black601", q8, 24'h108080);
    check("black601_10", q10, {10'd64, 10'd512, 10'd512});

    // Mode 2 (601 inv), first pixel on the same edge as the vs rise
    d_md = 2'd2;
    step(0, 1, 1, 24'hEB8080, 30'h3FFFFFFF);
    step(0, 1, 1, 24'hFFFFFF, {10'd64, 10'd512, 10'd512});
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("mode2_act", ma8, 3'b010);
    check("yuv2rgb_white", q8, 24'hFFFFFF);
    step(0, 0, 0, 0, 0);
    check("yuv2rgb_clamp", q8, 24'hFF7DFF);

    // Mode request 0 -> 1 mid-frame is held off until the next vs rise.
    // Integer rounding gives Y(red) = 81 for 601 and 63 for 709.
    d_md = 2'd0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    d_md = 2'd1;
    step(0, 0, 1, 24'hFF0000, 30'h3FF00000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("midframe_act", ma8, 3'b000);
    check("red601_y", q8[23:16], 8'd81);
    step(0, 1, 1, 24'hFF0000, 30'h3FF00000);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("mode709_act", ma8, 3'b001);
    check("red709_y", q8[23:16], 8'd63);

    // Bypass ramp
    d_bp = 1'b1;
    d_md = 2'd3;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      v8  = 8'(i);
      v10 = 10'(i * 4);
      step(0, 0, 1, {v8, v8, v8}, {v10, v10, v10});
      if (i >= 3) check("bypass_ramp", q8, {3{8'(i - 3)}});
    end
    check("bypass_flag", ma8[2], 1'b1);

    // Reset mid-line with continuous de
    d_bp = 1'b0;
    d_md = 2'd1;
    d_hs = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 24'($urandom), 30'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 24'($urandom), 30'($urandom));
    check("pre_rst_act", ma8, 3'b001);
    step(1, 0, 1, 24'($urandom), 30'($urandom));
    check("rst_outputs", {vs8, hs8, de8, q8}, 27'd0);
    check("rst_mode_mid", ma8, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 24'($urandom), 30'($urandom));
      check("resume_de", de8, k == 4);
    end
    check("rst_mode_hold", ma8, 3'd0);
    step(0, 1, 1, 24'($urandom), 30'($urandom));
    check("mode_relatch", ma8, 3'b001);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      d_hs = 1'($urandom_range(0, 1));
      d_md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) d_bp = 1'($urandom_range(0, 1));
      step($urandom_range(0, 249) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, 24'($urandom), 30'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
